// File: rtl/mcu32x_pkg.sv
// rtl/mcu32x_pkg.sv - shared widths and arbiter state encodings for the MCU32X memory port
package mcu32x_pkg;

   localparam int MCU32X_ADDR_W = 32;
   localparam int MCU32X_DATA_W = 32;

   localparam logic [1:0] ARB_IDLE   = 2'd0;
   localparam logic [1:0] ARB_ACC_IF = 2'd1;
   localparam logic [1:0] ARB_ACC_D  = 2'd2;
   localparam logic [1:0] ARB_RESP   = 2'd3;

endpackage

// File: rtl/mcu32x_arb_timeout.sv
// rtl/mcu32x_arb_timeout.sv - loadable saturating wait-state counter with expiry flag
module mcu32x_arb_timeout #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic inc_i,
   output logic expired_o
);

   localparam int            CW   = $clog2(LIMIT + 1);
   localparam logic [CW-1:0] MAX  = CW'(LIMIT);
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Clear has priority; otherwise count up and stick at LIMIT.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // High in the cycle whose missing ready brings the count up to LIMIT.
   assign expired_o = (cnt_q >= LAST);

endmodule

// File: rtl/mcu32x_mem_arbiter.sv
// rtl/mcu32x_mem_arbiter.sv - fetch/data arbiter for the single MCU32X memory port
module mcu32x_mem_arbiter
   import mcu32x_pkg::*;
#(
   parameter int ADDR_W       = MCU32X_ADDR_W,
   parameter int DATA_W       = MCU32X_DATA_W,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_done,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_done,
   output logic                err,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_read,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ready
);

   localparam int            BE_W       = DATA_W / 8;
   localparam int            SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic [1:0]        state_q,     state_d;
   logic [SW-1:0]     starve_q,    starve_d;
   logic              we_q,        we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic              mem_read_q,  mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [BE_W-1:0]   mem_be_q,    mem_be_d;
   logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
   logic              if_done_q,   if_done_d;
   logic              d_done_q,    d_done_d;
   logic              err_q,       err_d;

   logic to_clear;
   logic to_inc;
   logic to_expired;
   logic d_wins;

   // Data wins a tie unless fetch has been passed over STARVE_LIMIT times in a row.
   assign d_wins = d_req && !(if_req && (starve_q == STARVE_MAX));

   mcu32x_arb_timeout #(
      .LIMIT (TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (to_clear),
      .inc_i     (to_inc),
      .expired_o (to_expired)
   );

   // Next-state logic: arbitration in IDLE, wait/timeout in ACC_*, one-cycle response.
   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      we_d        = we_q;
      mem_addr_d  = mem_addr_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      if_rdata_d  = '0;
      d_rdata_d   = '0;
      if_done_d   = 1'b0;
      d_done_d    = 1'b0;
      err_d       = 1'b0;
      to_clear    = 1'b0;
      to_inc      = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            if (d_wins) begin
               state_d     = ARB_ACC_D;
               we_d        = d_we;
               mem_addr_d  = d_addr;
               mem_read_d  = !d_we;
               mem_write_d = d_we;
               mem_wdata_d = d_we ? d_wdata : '0;
               mem_be_d    = d_we ? d_be : '1;
               to_clear    = 1'b1;
               if (if_req && (starve_q != STARVE_MAX)) begin
                  starve_d = starve_q + 1'b1;
               end
            end else if (if_req) begin
               state_d     = ARB_ACC_IF;
               we_d        = 1'b0;
               mem_addr_d  = if_addr;
               mem_read_d  = 1'b1;
               mem_write_d = 1'b0;
               mem_wdata_d = '0;
               mem_be_d    = '1;
               to_clear    = 1'b1;
               starve_d    = '0;
            end
         end

         ARB_ACC_IF, ARB_ACC_D: begin
            if (mem_ready || to_expired) begin
               state_d     = ARB_RESP;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               err_d       = !mem_ready;
               if (state_q == ARB_ACC_IF) begin
                  if_done_d  = 1'b1;
                  if_rdata_d = mem_ready ? mem_rdata : '0;
               end else begin
                  d_done_d   = 1'b1;
                  d_rdata_d  = (mem_ready && !we_q) ? mem_rdata : '0;
               end
            end else begin
               to_inc = 1'b1;
            end
         end

         ARB_RESP: begin
            state_d = ARB_IDLE;
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops strobes and any pending done at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ARB_IDLE;
         starve_q    <= '0;
         we_q        <= 1'b0;
         mem_addr_q  <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         we_q        <= we_d;
         mem_addr_q  <= mem_addr_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_done_q   <= if_done_d;
         d_done_q    <= d_done_d;
         err_q       <= err_d;
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign if_done   = if_done_q;
   assign d_done    = d_done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mcu32x_mem_arbiter.sv
// tb/tb_mcu32x_mem_arbiter.sv - directed and random self-checking bench for mcu32x_mem_arbiter
module tb_mcu32x_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        err;
   logic [31:0] mem_addr;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   int n_checks = 0;
   int n_errors = 0;

   int waits = 0;
   bit hang  = 0;
   int strobe_age;

   int          both_hi   = 0;
   int          rd_cycles = 0;
   int          wr_cycles = 0;
   int          if_dones  = 0;
   int          d_dones   = 0;
   int          grants    = 0;
   logic        prev_strobe = 1'b0;
   logic [31:0] last_wdata  = '0;
   logic [3:0]  last_be     = '0;
   byte         order[$];

   mcu32x_mem_arbiter #(
      .ADDR_W       (32),
      .DATA_W       (32),
      .STARVE_LIMIT (4),
      .TIMEOUT      (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_done   (if_done),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_be      (d_be),
      .d_rdata   (d_rdata),
      .d_done    (d_done),
      .err       (err),
      .mem_addr  (mem_addr),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory model: ready after 'waits' strobe cycles, never while 'hang' is set.
   initial begin
      mem_ready  = 1'b0;
      mem_rdata  = '0;
      strobe_age = 0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_read || mem_write) strobe_age++;
         else strobe_age = 0;
         mem_ready = (strobe_age > waits) && !hang;
         mem_rdata = model_rd(mem_addr);
      end
   end

   // Bus monitor: strobe statistics, grants and completion order.
   always @(negedge clk) begin
      if (mem_read && mem_write) both_hi <= both_hi + 1;
      if (mem_read) rd_cycles <= rd_cycles + 1;
      if (mem_write) begin
         wr_cycles  <= wr_cycles + 1;
         last_wdata <= mem_wdata;
      end
      if (mem_read || mem_write) last_be <= mem_be;
      if ((mem_read || mem_write) && !prev_strobe) grants <= grants + 1;
      prev_strobe <= mem_read || mem_write;
      if (if_done) begin
         if_dones <= if_dones + 1;
         order.push_back(8'h49);
      end
      if (d_done) begin
         d_dones <= d_dones + 1;
         order.push_back(8'h44);
      end
   end

   // One request held until its done pulse; lat counts sampled cycles from request to done.
   task automatic do_access(input bit is_d, input bit we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] be,
                            output logic [31:0] rdata, output bit e, output int lat);
      bit ok;
      int n;
      ok    = 1'b0;
      n     = 0;
      rdata = '0;
      e     = 1'b0;
      @(posedge clk);
      #1;
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd; d_be = be;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      while (!ok && n < 60) begin
         @(negedge clk);
         n++;
         if (is_d ? d_done : if_done) begin
            ok    = 1'b1;
            rdata = is_d ? d_rdata : if_rdata;
            e     = err;
         end
      end
      lat = n;
      @(posedge clk);
      #1;
      if_req = 1'b0;
      d_req  = 1'b0;
      check("done_seen", 32'(ok), 32'h1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  be;
      bit          e;
      bit          is_d;
      bit          we;
      int          lat;
      int          n;
      int          s_rd, s_wr, s_dd, s_id, s_g;

      reset = 1'b1;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_read",  32'(mem_read),  32'h0);
      check("rst_write", 32'(mem_write), 32'h0);
      check("rst_ifdone", 32'(if_done),  32'h0);
      check("rst_ddone", 32'(d_done),    32'h0);
      check("rst_err",   32'(err),       32'h0);
      check("rst_addr",  mem_addr,       32'h0);
      check("rst_be",    32'(mem_be),    32'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // 1: single load, zero wait states
      waits = 0;
      @(posedge clk);
      #1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      @(negedge clk);
      check("t1_c0_read", 32'(mem_read), 32'h0);
      @(negedge clk);
      check("t1_c1_read", 32'(mem_read), 32'h1);
      check("t1_c1_addr", mem_addr, 32'h100);
      check("t1_c1_be",   32'(mem_be), 32'hF);
      check("t1_c1_done", 32'(d_done), 32'h0);
      @(negedge clk);
      check("t1_c2_done",  32'(d_done), 32'h1);
      check("t1_c2_rdata", d_rdata, model_rd(32'h100));
      check("t1_c2_err",   32'(err), 32'h0);
      check("t1_c2_read",  32'(mem_read), 32'h0);
      @(posedge clk);
      #1;
      d_req = 1'b0;
      @(negedge clk);
      check("t1_c3_done", 32'(d_done), 32'h0);
      repeat (2) @(negedge clk);

      // 2: store with three wait states
      s_wr = wr_cycles; s_dd = d_dones; s_id = if_dones;
      waits = 3;
      do_access(1'b1, 1'b1, 32'h204, 32'hDEAD_BEEF, 4'b0011, rd, e, lat);
      repeat (3) @(negedge clk);
      check("t2_wr_cycles", 32'(wr_cycles - s_wr), 32'd4);
      check("t2_ddones",    32'(d_dones - s_dd), 32'd1);
      check("t2_ifdones",   32'(if_dones - s_id), 32'd0);
      check("t2_be",        32'(last_be), 32'h3);
      check("t2_wdata",     last_wdata, 32'hDEAD_BEEF);
      check("t2_rdata",     rd, 32'h0);
      check("t2_err",       32'(e), 32'h0);
      check("t2_lat",       32'(lat), 32'd6);

      // 3: both requesters held high, fetch wins every fifth grant
      order.delete();
      waits = 0;
      @(posedge clk);
      #1;
      if_req = 1'b1; if_addr = 32'h40;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
      n = 0;
      while (order.size() < 10 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      if_req = 1'b0;
      d_req  = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("t3_grant%0d", i), 32'(order[i]), (i % 5 == 4) ? 32'h49 : 32'h44);
      end

      // 4: memory never ready, timeout then a normal fetch
      s_rd = rd_cycles;
      hang = 1'b1;
      do_access(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, rd, e, lat);
      repeat (2) @(negedge clk);
      check("t4_rd_cycles", 32'(rd_cycles - s_rd), 32'd8);
      check("t4_err",   32'(e), 32'h1);
      check("t4_rdata", rd, 32'h0);
      check("t4_lat",   32'(lat), 32'd10);
      hang  = 1'b0;
      waits = 1;
      s_rd  = rd_cycles;
      do_access(1'b0, 1'b0, 32'h344, 32'h0, 4'h0, rd, e, lat);
      repeat (2) @(negedge clk);
      check("t4b_rdata", rd, model_rd(32'h344));
      check("t4b_err",   32'(e), 32'h0);
      check("t4b_lat",   32'(lat), 32'd4);
      check("t4b_rd_cycles", 32'(rd_cycles - s_rd), 32'd2);

      // 5: reset in the middle of a stalled store
      s_dd = d_dones;
      hang = 1'b1;
      @(posedge clk);
      #1;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h1234_5678; d_be = 4'hF;
      repeat (3) @(negedge clk);
      check("t5_pre_write", 32'(mem_write), 32'h1);
      reset = 1'b1;
      #1;
      check("t5_rst_write", 32'(mem_write), 32'h0);
      check("t5_rst_read",  32'(mem_read), 32'h0);
      d_req = 1'b0;
      repeat (2) @(negedge clk);
      check("t5_rst_done", 32'(d_done), 32'h0);
      reset = 1'b0;
      hang  = 1'b0;
      waits = 0;
      repeat (3) @(negedge clk);
      check("t5_no_done", 32'(d_dones - s_dd), 32'd0);
      do_access(1'b1, 1'b0, 32'h600, 32'h0, 4'h0, rd, e, lat);
      check("t5_post_rdata", rd, model_rd(32'h600));
      check("t5_post_err",   32'(e), 32'h0);
      check("t5_post_lat",   32'(lat), 32'd3);
      repeat (3) @(negedge clk);

      // 6: random single accesses with random wait states
      s_g = grants; s_id = if_dones; s_dd = d_dones;
      for (int i = 0; i < 30; i++) begin
         is_d  = 1'($urandom_range(1, 0));
         we    = is_d & 1'($urandom_range(1, 0));
         a     = $urandom;
         wd    = $urandom;
         be    = 4'($urandom_range(15, 0));
         waits = int'($urandom_range(4, 0));
         do_access(is_d, we, a, wd, be, rd, e, lat);
         check("t6_rdata", rd, (is_d && we) ? 32'h0 : model_rd(a));
         check("t6_err",   32'(e), 32'h0);
         check("t6_lat",   32'(lat), 32'(3 + waits));
         if (is_d && we) begin
            @(negedge clk);
            check("t6_wdata", last_wdata, wd);
         end
      end
      repeat (4) @(negedge clk);
      check("t6_done_per_grant", 32'((if_dones - s_id) + (d_dones - s_dd)), 32'(grants - s_g));
      check("strobe_exclusive", 32'(both_hi), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
